// File: rtl/sampler_accept_stage.sv
// sampler_accept_stage
//   Rejection-sampling loop around a combinational constraint checker.
//   An internal xorshift generator drives candidates onto cand_out. The
//   checker's verdict (chk_sat) either accepts a candidate into a small
//   FIFO or rejects it. A run ends after n_samples accepts or MAX_TRIES
//   tries, whichever comes first. If both happen on the same cycle, the
//   accept wins.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse; begins a run from IDLE or DONE
//   n_samples    accepted samples requested (latched on start)
//   cand_out     candidate presented to the checker
//   chk_sat      checker verdict for cand_out (same cycle)
//   smp_valid    FIFO non-empty
//   smp_ready    downstream ready; pop on smp_valid & smp_ready
//   smp_data     FIFO head (0 when empty)
//   busy/done    state is RUN / DONE
//   timeout      last run ended on the try budget
//   tries_cnt    tries in the current run
//   accept_cnt   samples pushed in the current run
module sampler_accept_stage #(
  parameter int unsigned W          = 64,
  parameter logic [63:0] SEED       = 64'h0123_4567_89AB_CDEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_TRIES  = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   n_samples,
  output logic [W-1:0]  cand_out,
  input  logic          chk_sat,
  output logic          smp_valid,
  input  logic          smp_ready,
  output logic [W-1:0]  smp_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   tries_cnt,
  output logic [15:0]   accept_cnt
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [W-1:0] SEED_W = W'(SEED);
  localparam logic [31:0]  MAX_T  = 32'(MAX_TRIES);
  localparam logic [AW:0]  FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    cand;
  logic [15:0]     n_lat;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic start_ok, is_run, full, push, try_step, pop;
  logic acc_hit, try_hit, timeout_set;

  function automatic logic [W-1:0] xs_next(input logic [W-1:0] c);
    logic [W-1:0] t1, t2;
    t1 = c ^ (c << 13);
    t2 = t1 ^ (t1 >> 7);
    return t2 ^ (t2 << 17);
  endfunction

  assign is_run   = (state == S_RUN);
  assign start_ok = start && (state != S_RUN);
  // Fullness is judged before any same-cycle pop.
  assign full     = (count == FULL_C);
  assign push     = is_run && chk_sat && !full;
  // Every RUN cycle that is not a stall consumes a try.
  assign try_step = is_run && (!chk_sat || !full);
  assign pop      = smp_valid && smp_ready;
  assign acc_hit  = push && ((accept_cnt + 16'd1) == n_lat);
  assign try_hit  = try_step && ((tries_cnt + 32'd1) == MAX_T);
  assign timeout_set = try_hit && !acc_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (n_samples == 16'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (acc_hit || try_hit) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= SEED_W;
      n_lat      <= '0;
      tries_cnt  <= '0;
      accept_cnt <= '0;
      timeout    <= 1'b0;
    end else if (start_ok) begin
      cand       <= SEED_W;
      n_lat      <= n_samples;
      tries_cnt  <= '0;
      accept_cnt <= '0;
      timeout    <= 1'b0;
    end else if (try_step) begin
      cand      <= xs_next(cand);
      tries_cnt <= tries_cnt + 32'd1;
      if (push)        accept_cnt <= accept_cnt + 16'd1;
      if (timeout_set) timeout    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign cand_out  = cand;
  assign smp_valid = (count != '0);
  assign smp_data  = smp_valid ? mem[rd_ptr] : '0;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_sampler_accept_stage.sv
// tb_sampler_accept_stage
//   Randomised bench with a queue-based reference model of the sampler,
//   plus directed scenarios pinned by literal expectations. A second
//   instance with a three-try budget covers the accept/timeout tie.
module tb_sampler_accept_stage;

  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
  localparam int MAXT  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start, smp_ready, rnd_sat;
  logic [15:0] n_samples;
  int mode;  // 0 random verdict, 1 always sat, 2 never sat, 3 sat = bit0
  logic [63:0] cand_out, smp_data;
  logic chk_sat, smp_valid, busy, done, timeout;
  logic [31:0] tries_cnt;
  logic [15:0] accept_cnt;

  logic t_start, t_sat, t_ready;
  logic [15:0] t_n;
  logic [63:0] t_cand, t_data;
  logic t_valid, t_busy, t_done, t_timeout;
  logic [31:0] t_tries;
  logic [15:0] t_acc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign chk_sat = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 :
                   (mode == 3) ? cand_out[0] : rnd_sat;

  sampler_accept_stage #(.W(64), .SEED(SEED), .FIFO_DEPTH(DEPTH), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .cand_out(cand_out), .chk_sat(chk_sat), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .smp_data(smp_data), .busy(busy), .done(done),
    .timeout(timeout), .tries_cnt(tries_cnt), .accept_cnt(accept_cnt)
  );

  sampler_accept_stage #(.W(64), .SEED(SEED), .FIFO_DEPTH(4), .MAX_TRIES(3)) u_tie (
    .clk(clk), .rst(rst), .start(t_start), .n_samples(t_n),
    .cand_out(t_cand), .chk_sat(t_sat), .smp_valid(t_valid),
    .smp_ready(t_ready), .smp_data(t_data), .busy(t_busy), .done(t_done),
    .timeout(t_timeout), .tries_cnt(t_tries), .accept_cnt(t_acc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] gen(input logic [63:0] c);
    logic [63:0] a, b;
    a = c ^ (c << 13);
    b = a ^ (a >> 7);
    return b ^ (b << 17);
  endfunction

  function automatic bit verdict(input logic [63:0] c);
    case (mode)
      1: return 1'b1;
      2: return 1'b0;
      3: return c[0];
      default: return rnd_sat;
    endcase
  endfunction

  logic [63:0] q[$];
  logic [63:0] m_cand;
  int m_tries, m_acc, m_n;
  bit m_run, m_fin, m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cand = SEED; m_tries = 0; m_acc = 0; m_n = 0;
      m_run = 0; m_fin = 0; m_to = 0;
    end else begin
      bit do_pop, do_push, sat;
      logic [63:0] pushed;
      do_pop  = (q.size() > 0) && smp_ready;
      do_push = 0;
      pushed  = '0;
      if (start && !m_run) begin
        m_n = int'(n_samples); m_cand = SEED; m_tries = 0; m_acc = 0; m_to = 0;
        m_run = (m_n != 0); m_fin = (m_n == 0);
      end else if (m_run) begin
        sat = verdict(m_cand);
        if (!(sat && q.size() == DEPTH)) begin
          m_tries++;
          if (sat) begin
            do_push = 1; pushed = m_cand; m_acc++;
          end
          m_cand = gen(m_cand);
          if (sat && m_acc == m_n) begin
            m_run = 0; m_fin = 1; m_to = 0;
          end else if (m_tries == MAXT) begin
            m_run = 0; m_fin = 1; m_to = 1;
          end
        end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pushed);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cand_out",   cand_out,   m_cand);
      chk("smp_valid",  {63'd0, smp_valid}, {63'd0, q.size() > 0});
      chk("smp_data",   smp_data,   (q.size() > 0) ? q[0] : 64'd0);
      chk("busy",       {63'd0, busy},    {63'd0, m_run});
      chk("done",       {63'd0, done},    {63'd0, m_fin});
      chk("timeout",    {63'd0, timeout}, {63'd0, m_to});
      chk("tries_cnt",  {32'd0, tries_cnt},  64'(m_tries));
      chk("accept_cnt", {48'd0, accept_cnt}, 64'(m_acc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic kick(input int n);
    start = 1'b1;
    n_samples = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    for (int k = 0; k < maxc; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cand"},  cand_out, SEED);
    chk({tag, "_valid"}, {63'd0, smp_valid}, 64'd0);
    chk({tag, "_data"},  smp_data, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_done"},  {63'd0, done}, 64'd0);
    chk({tag, "_to"},    {63'd0, timeout}, 64'd0);
    chk({tag, "_tries"}, {32'd0, tries_cnt}, 64'd0);
    chk({tag, "_acc"},   {48'd0, accept_cnt}, 64'd0);
  endtask

  initial begin
    start = 0; n_samples = 0; smp_ready = 1; rnd_sat = 0; mode = 1;
    t_start = 0; t_n = 0; t_sat = 1; t_ready = 1;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Happy path: three straight accepts.
    mode = 1; smp_ready = 1;
    kick(3);
    chk("hp_cand_seed", cand_out, 64'h0123_4567_89AB_CDEF);
    chk("hp_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("hp_first_data", smp_data, 64'h0123_4567_89AB_CDEF);
    chk("hp_first_valid", {63'd0, smp_valid}, 64'd1);
    repeat (2) @(negedge clk);
    chk("hp_done", {63'd0, done}, 64'd1);
    chk("hp_tries", {32'd0, tries_cnt}, 64'd3);
    chk("hp_acc", {48'd0, accept_cnt}, 64'd3);
    chk("hp_to", {63'd0, timeout}, 64'd0);
    repeat (3) @(negedge clk);

    // Timeout: never satisfied, budget of 16 tries.
    mode = 2;
    kick(5);
    repeat (15) @(negedge clk);
    chk("to_not_yet", {63'd0, done}, 64'd0);
    chk("to_tries15", {32'd0, tries_cnt}, 64'd15);
    @(negedge clk);
    chk("to_done", {63'd0, done}, 64'd1);
    chk("to_flag", {63'd0, timeout}, 64'd1);
    chk("to_tries", {32'd0, tries_cnt}, 64'd16);
    chk("to_acc", {48'd0, accept_cnt}, 64'd0);

    // Backpressure: FIFO fills, then stalls until drained.
    mode = 1; smp_ready = 0;
    kick(6);
    repeat (4) @(negedge clk);
    chk("bp_tries4", {32'd0, tries_cnt}, 64'd4);
    repeat (3) @(negedge clk);
    chk("bp_frozen", {32'd0, tries_cnt}, 64'd4);
    chk("bp_busy", {63'd0, busy}, 64'd1);
    chk("bp_acc4", {48'd0, accept_cnt}, 64'd4);
    smp_ready = 1;
    wait_done(20, "bp_wait_done");
    chk("bp_tries6", {32'd0, tries_cnt}, 64'd6);
    chk("bp_acc6", {48'd0, accept_cnt}, 64'd6);
    repeat (6) @(negedge clk);

    // Filter on bit 0.
    mode = 3;
    kick(4);
    wait_done(40, "filt_wait_done");
    repeat (6) @(negedge clk);

    // Zero samples requested.
    kick(0);
    chk("n0_done", {63'd0, done}, 64'd1);
    chk("n0_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);

    // Tie on the 3-try instance: accept wins; one sample short times out.
    t_n = 16'd3; t_start = 1;
    @(negedge clk);
    t_start = 0;
    repeat (3) @(negedge clk);
    chk("tie_done", {63'd0, t_done}, 64'd1);
    chk("tie_to", {63'd0, t_timeout}, 64'd0);
    chk("tie_tries", {32'd0, t_tries}, 64'd3);
    chk("tie_acc", {48'd0, t_acc}, 64'd3);
    t_n = 16'd4; t_start = 1;
    @(negedge clk);
    t_start = 0;
    repeat (3) @(negedge clk);
    chk("short_done", {63'd0, t_done}, 64'd1);
    chk("short_to", {63'd0, t_timeout}, 64'd1);
    chk("short_acc", {48'd0, t_acc}, 64'd3);

    // Reset while busy.
    mode = 0; smp_ready = 0; rnd_sat = 1;
    kick(8);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_busy");
    @(negedge clk);
    rst = 1'b0;

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 15) == 0);
      n_samples = 16'($urandom_range(0, 7));
      if (start) mode = ($urandom_range(0, 3) == 0) ? 3 : 0;
      rnd_sat   = ($urandom_range(0, 2) != 0);
      smp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    start = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
